// File: rtl/operand_arbiter_pkg.sv
// Shared definitions for the operand-path arbiters: state encoding, requester
// count, select width and the index-to-one-hot helper.
package operand_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    localparam logic [SEL_W-1:0] SEL_ONE = 2'd1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_REQ-1:0] oh;
        oh      = {NUM_REQ{1'b0}};
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/operand_arbiter_rr_pick4.sv
// Combinational round-robin picker: first set request at ptr, ptr+1, ptr+2,
// ptr+3 (mod 4). Holds no state.
module rr_pick4
    import operand_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    logic [2*NUM_REQ-1:0] dbl_s;
    logic [NUM_REQ-1:0]   rot_s;
    logic [SEL_W-1:0]     off_s;

    // Rotate so bit 0 of rot_s is the requester currently holding priority.
    assign dbl_s = {req, req};
    assign rot_s = dbl_s[{1'b0, ptr} +: NUM_REQ];

    // Fixed-priority search over the rotated request vector.
    always_comb begin
        off_s = 2'd0;
        found = 1'b0;
        casez (rot_s)
            4'b???1: begin off_s = 2'd0; found = 1'b1; end
            4'b??10: begin off_s = 2'd1; found = 1'b1; end
            4'b?100: begin off_s = 2'd2; found = 1'b1; end
            4'b1000: begin off_s = 2'd3; found = 1'b1; end
            default: begin off_s = 2'd0; found = 1'b0; end
        endcase
    end

    assign idx = ptr + off_s;

endmodule

// File: rtl/operand_arbiter.sv
// Round-robin owner arbiter for the shared 4:1 operand path. Holds the grant
// until done or a forced timeout release, then re-arbitrates on the same edge.
module operand_arbiter
    import operand_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 16
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] grant,
    output logic [SEL_W-1:0]   select,
    output logic               busy,
    output logic               timeout
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    arb_state_e         state_r, state_nxt_s;
    logic [SEL_W-1:0]   ptr_r, ptr_nxt_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
    logic [NUM_REQ-1:0] grant_r, grant_nxt_s;
    logic [SEL_W-1:0]   select_r, select_nxt_s;
    logic               busy_r;
    logic               timeout_r, timeout_nxt_s;

    logic               release_s;
    logic [SEL_W-1:0]   arb_ptr_s;
    logic               pick_found_s;
    logic [SEL_W-1:0]   pick_idx_s;

    // On a release edge the pointer already moves past the owner for this pick.
    assign release_s = (state_r == BUSY) && (done || (cnt_r == CNT_LAST));
    assign arb_ptr_s = release_s ? (select_r + SEL_ONE) : ptr_r;

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (arb_ptr_s),
        .found (pick_found_s),
        .idx   (pick_idx_s)
    );

    // Next-state, grant, pointer and timeout-counter logic.
    always_comb begin
        state_nxt_s   = state_r;
        ptr_nxt_s     = ptr_r;
        cnt_nxt_s     = cnt_r;
        grant_nxt_s   = grant_r;
        select_nxt_s  = select_r;
        timeout_nxt_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (pick_found_s) begin
                    state_nxt_s  = BUSY;
                    grant_nxt_s  = idx_to_onehot(pick_idx_s);
                    select_nxt_s = pick_idx_s;
                    cnt_nxt_s    = CNT_ZERO;
                end else begin
                    state_nxt_s = IDLE;
                    grant_nxt_s = {NUM_REQ{1'b0}};
                end
            end
            BUSY: begin
                if (release_s) begin
                    ptr_nxt_s     = arb_ptr_s;
                    // done wins over a coinciding counter expiry
                    timeout_nxt_s = ~done;
                    cnt_nxt_s     = CNT_ZERO;
                    if (pick_found_s) begin
                        state_nxt_s  = BUSY;
                        grant_nxt_s  = idx_to_onehot(pick_idx_s);
                        select_nxt_s = pick_idx_s;
                    end else begin
                        state_nxt_s = IDLE;
                        grant_nxt_s = {NUM_REQ{1'b0}};
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                grant_nxt_s = {NUM_REQ{1'b0}};
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            ptr_r     <= {SEL_W{1'b0}};
            cnt_r     <= CNT_ZERO;
            grant_r   <= {NUM_REQ{1'b0}};
            select_r  <= {SEL_W{1'b0}};
            busy_r    <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            ptr_r     <= ptr_nxt_s;
            cnt_r     <= cnt_nxt_s;
            grant_r   <= grant_nxt_s;
            select_r  <= select_nxt_s;
            busy_r    <= |grant_nxt_s;
            timeout_r <= timeout_nxt_s;
        end
    end

    assign grant   = grant_r;
    assign select  = select_r;
    assign busy    = busy_r;
    assign timeout = timeout_r;

endmodule

// File: tb/tb_operand_arbiter.sv
// Self-checking bench for operand_arbiter: a vector table plus hand-written
// timeout sequences, compared through an expected-result queue.
module tb_operand_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] select;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] sel;
        logic       busy;
        logic       to;
    } exp_t;

    typedef struct packed {
        logic       rst;
        logic [3:0] req;
        logic       done;
        logic [3:0] grant;
        logic [1:0] sel;
        logic       to;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    operand_arbiter #(.TIMEOUT(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .done    (done),
        .grant   (grant),
        .select  (select),
        .busy    (busy),
        .timeout (timeout)
    );

    function automatic vec_t v(input logic r, input logic [3:0] rq, input logic d,
                               input logic [3:0] g, input logic [1:0] s, input logic t);
        return {r, rq, d, g, s, t};
    endfunction

    // Drive one edge worth of inputs, queue the expectation, check after the edge.
    task automatic step(input logic r, input logic [3:0] rq, input logic d,
                        input logic [3:0] eg, input logic [1:0] es, input logic eto,
                        input string name, input int idx);
        exp_t e;
        exp_t a;
        reset = r;
        req   = rq;
        done  = d;
        e.grant = eg;
        e.sel   = es;
        e.busy  = |eg;
        e.to    = eto;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        a = {grant, select, busy, timeout};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s[%0d]: got grant=%b select=%0d busy=%b timeout=%b, want grant=%b select=%0d busy=%b timeout=%b",
                     name, idx, a.grant, a.sel, a.busy, a.to, e.grant, e.sel, e.busy, e.to);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        req   = 4'b0000;
        done  = 1'b0;

        // Single requester 2, done three cycles after grant, back-to-back regrant
        tbl.push_back(v(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0));
        tbl.push_back(v(1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0));
        tbl.push_back(v(1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0));
        tbl.push_back(v(1'b0, 4'b0111, 1'b0, 4'b0100, 2'd2, 1'b0));
        tbl.push_back(v(1'b0, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b0));
        tbl.push_back(v(1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0));
        tbl.push_back(v(1'b0, 4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0));
        // done in IDLE is ignored, select holds
        tbl.push_back(v(1'b0, 4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0));
        tbl.push_back(v(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0));
        // All requesting, done every cycle: rotation 0,1,2,3,0
        tbl.push_back(v(1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0));
        tbl.push_back(v(1'b0, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b0));
        tbl.push_back(v(1'b0, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b0));
        tbl.push_back(v(1'b0, 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b0));
        tbl.push_back(v(1'b0, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b0));
        tbl.push_back(v(1'b0, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b0));
        tbl.push_back(v(1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0));
        // Pointer is now 1: requesters 0 and 3 pending -> 3 wins
        tbl.push_back(v(1'b0, 4'b1001, 1'b0, 4'b1000, 2'd3, 1'b0));
        // Reset mid-transaction with req 1010, then restart from ptr 0
        tbl.push_back(v(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0));
        tbl.push_back(v(1'b0, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b0));
        tbl.push_back(v(1'b0, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b0));
        tbl.push_back(v(1'b1, 4'b1010, 1'b1, 4'b0000, 2'd0, 1'b0));
        tbl.push_back(v(1'b0, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b0));
        tbl.push_back(v(1'b0, 4'b1010, 1'b1, 4'b1000, 2'd3, 1'b0));
        tbl.push_back(v(1'b0, 4'b0000, 1'b1, 4'b0000, 2'd3, 1'b0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].done, tbl[i].grant, tbl[i].sel, tbl[i].to, "tbl", i);
        end

        // Sole requester 0, no done: held 16 cycles, one-cycle timeout pulse, regrant
        step(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "to_rst", 0);
        step(1'b0, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, "to_grant", 0);
        for (int i = 1; i < 16; i++) begin
            step(1'b0, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, "to_hold", i);
        end
        step(1'b0, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, "to_pulse", 0);
        step(1'b0, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, "to_after", 0);
        step(1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, "to_idle", 0);
        step(1'b0, 4'b0011, 1'b0, 4'b0010, 2'd1, 1'b0, "to_ptr", 0);

        // Owner drops req; done coincides with the last counter value: no pulse
        step(1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "dn_rst", 0);
        step(1'b0, 4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, "dn_grant", 0);
        for (int i = 1; i < 16; i++) begin
            step(1'b0, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b0, "dn_hold", i);
        end
        step(1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, "dn_release", 0);
        step(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "dn_idle", 0);

        // Reset beats an imminent timeout
        step(1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0, "rt_grant", 0);
        for (int i = 1; i < 16; i++) begin
            step(1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b0, "rt_hold", i);
        end
        step(1'b1, 4'b0100, 1'b0, 4'b0000, 2'd0, 1'b0, "rt_reset", 0);
        step(1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "rt_idle", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_arbiter.md
OPERAND_ARBITER -- requirements
Module: operand_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16: max BUSY cycles without done before forced release; legal range 2..255.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  4  per-requester request; bit i = requester i wants the shared 4:1 operand path.
REQ-005 done  input  1  shared resource finished current transaction; sampled only in BUSY.
REQ-006 grant  output  4  one-hot registered grant; all-zero when no owner.
REQ-007 select  output  2  registered binary index of current or last owner; drives the 4:1 mux select.
REQ-008 busy  output  1  high while grant is non-zero.
REQ-009 timeout  output  1  one-cycle pulse on forced release.

Function
REQ-010 The block SHALL have two states: IDLE (no owner) and BUSY (one owner).
REQ-011 The block SHALL keep a 2-bit round-robin pointer ptr; the winner is the first set req bit at index ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-012 In IDLE with req != 0 at edge N, the block SHALL assert grant, select = winner, busy = 1 after edge N (1-cycle latency) and enter BUSY.
REQ-013 In IDLE with req == 0, grant SHALL stay 0 and select SHALL hold its last value.
REQ-014 In BUSY, grant and select SHALL stay constant until release, regardless of req changes, including the owner dropping its req.
REQ-015 Release SHALL occur on an edge where done == 1, or on timeout (REQ-018).
REQ-016 On release, ptr SHALL become (owner + 1) mod 4 and arbitration SHALL use the req sampled on the same edge with the new ptr.
REQ-017 If that arbitration finds a winner, the block SHALL grant it directly with no idle bubble and stay in BUSY. Otherwise it SHALL enter IDLE with grant = 0.
REQ-018 A cycle counter SHALL clear on every new grant and increment on each BUSY cycle with done == 0.
REQ-019 When the counter reaches TIMEOUT-1 with done == 0, the block SHALL release and pulse timeout for exactly one cycle, coincident with the new grant/idle state.
REQ-020 If done and the timeout condition occur together, done SHALL take precedence and timeout SHALL NOT pulse.
REQ-021 done asserted in IDLE SHALL be ignored.
REQ-022 grant SHALL never have more than one bit set, and busy SHALL equal |grant at all times.
REQ-023 A sole persistent requester SHALL be re-granted back-to-back after each release.

Reset
REQ-024 With reset high at an edge, the block SHALL set state = IDLE, grant = 0, select = 2'b00, busy = 0, timeout = 0, ptr = 0 and counter = 0.
REQ-025 Reset asserted mid-transaction SHALL drop grant at that edge with no timeout pulse; reset SHALL have priority over done, req and timeout.
REQ-026 The first grant after reset release SHALL follow REQ-012 with ptr = 0.

Structure
REQ-027 A shared package/header SHALL hold the state encoding (IDLE, BUSY), the NUM_REQ = 4 constant and the select width constant, so the mux and other arbiters reuse them.
REQ-028 A single combinational sub-module rr_pick4 (inputs req[3:0] and ptr[1:0]; outputs found and idx[1:0]) SHALL implement winner selection. All registers SHALL stay in operand_arbiter.
REQ-029 The counter width SHALL be the minimum needed to hold TIMEOUT-1.

Verification
REQ-030 Reset, then req = 4'b0100 held, done pulsed 3 cycles after grant -> grant = 4'b0100 and select = 2'b10 one cycle after req; grant re-issued to requester 2 with no bubble after done.
REQ-031 req = 4'b1111 held, done every cycle -> grant order 0001, 0010, 0100, 1000, 0001; select 0, 1, 2, 3, 0.
REQ-032 req = 4'b0001, done never asserted, TIMEOUT = 16 -> grant held exactly 16 cycles, timeout high for 1 cycle, ptr = 1, requester 0 re-granted.
REQ-033 Owner drops req while BUSY and done coincides with counter = TIMEOUT-1 -> release, timeout stays 0, next state IDLE if req = 0.
REQ-034 Reset asserted during BUSY with req = 4'b1010 -> grant = 0 at that edge; after reset deasserts, grant = 4'b0010 one cycle later.
REQ-035 done pulsed in IDLE with req = 0 -> no state change, grant = 0, select unchanged.
